// File: rtl/move_scheduler.sv
// Merges key edges, key auto-repeat, level-scaled gravity and restart into a
// single valid/ready op stream for the game engine; play freezes while fail is high.
module move_scheduler #(
    parameter int unsigned CW           = 32,
    parameter int unsigned GRAV_BASE    = 100_000_000,
    parameter int unsigned GRAV_STEP    = 6_000_000,
    parameter int unsigned GRAV_MIN     = 10_000_000,
    parameter int unsigned REPEAT_DELAY = 25_000_000,
    parameter int unsigned REPEAT_RATE  = 8_000_000
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic       key_left,
    input  logic       key_right,
    input  logic       key_down,
    input  logic       key_up,
    input  logic       key_space,
    input  logic [6:0] score,
    input  logic       fail,
    input  logic       op_ready,
    output logic       op_valid,
    output logic [2:0] op_code,
    output logic [3:0] level
);

    typedef enum logic [1:0] {S_RUN, S_ISSUE, S_FAIL} state_t;

    typedef enum logic [2:0] {
        OP_NOP       = 3'd0,
        OP_LEFT      = 3'd1,
        OP_RIGHT     = 3'd2,
        OP_ROTATE    = 3'd3,
        OP_SOFT_DROP = 3'd4,
        OP_GRAVITY   = 3'd5,
        OP_RESTART   = 3'd6
    } op_t;

    // Pending-bit positions, ordered so the highest set bit wins arbitration.
    localparam int unsigned P_D = 0;
    localparam int unsigned P_R = 1;
    localparam int unsigned P_L = 2;
    localparam int unsigned P_U = 3;
    localparam int unsigned P_G = 4;
    localparam int unsigned P_S = 5;

    localparam logic [CW-1:0] BASE_C   = CW'(GRAV_BASE);
    localparam logic [CW-1:0] MIN_C    = CW'(GRAV_MIN);
    localparam logic [CW-1:0] MARGIN_C = CW'(GRAV_BASE - GRAV_MIN);
    localparam logic [CW-1:0] RATE_C   = CW'(REPEAT_RATE);
    // First load absorbs the input-register and edge stages so the first repeat
    // op lands REPEAT_DELAY cycles after the key pin edge.
    localparam logic [CW-1:0] FIRST_C  = CW'(REPEAT_DELAY - 3);

    state_t        state, state_n;
    op_t           op_q, op_n;
    logic [4:0]    key_q, key_prev, rise;
    logic          rise_l, rise_r;
    logic [CW-1:0] rep_cnt [3];
    logic [2:0]    rep_fire;
    logic [5:0]    pend, pend_set, pend_clr, cand, win_q, win_n;
    logic          active, latch, xfer, grav_wrap;
    logic [CW-1:0] grav_cnt, period_q, lvl_step, period_calc;
    logic          unused_score_lsbs;

    assign unused_score_lsbs = ^score[2:0];
    assign op_code = op_q;

    function automatic logic [5:0] top_bit(input logic [5:0] v);
        logic [5:0] r;
        r = '0;
        for (int unsigned i = 0; i < 6; i++) begin
            if (v[i]) begin
                r    = '0;
                r[i] = 1'b1;
            end
        end
        return r;
    endfunction

    function automatic op_t code_of(input logic [5:0] w);
        if (w[P_S])      return OP_RESTART;
        else if (w[P_G]) return OP_GRAVITY;
        else if (w[P_U]) return OP_ROTATE;
        else if (w[P_L]) return OP_LEFT;
        else if (w[P_R]) return OP_RIGHT;
        else if (w[P_D]) return OP_SOFT_DROP;
        else             return OP_NOP;
    endfunction

    always_comb begin
        rise   = key_q & ~key_prev;
        rise_l = rise[0] & ~rise[1];
        rise_r = rise[1] & ~rise[0];
        active = (state != S_FAIL);
        xfer   = (state == S_ISSUE) && op_ready;
        for (int unsigned i = 0; i < 3; i++) begin
            rep_fire[i] = active && key_q[i] && (rep_cnt[i] == CW'(1));
        end
        // Clamp before subtracting so deep levels cannot wrap the period.
        lvl_step    = CW'(level) * CW'(GRAV_STEP);
        period_calc = (lvl_step > MARGIN_C) ? MIN_C : BASE_C - lvl_step;
        grav_wrap   = active && (grav_cnt == period_q - CW'(1));

        pend_set      = '0;
        pend_set[P_L] = active & (rise_l | rep_fire[0]);
        pend_set[P_R] = active & (rise_r | rep_fire[1]);
        pend_set[P_D] = active & (rise[2] | rep_fire[2]);
        pend_set[P_U] = active & rise[3];
        pend_set[P_G] = grav_wrap;
        pend_set[P_S] = rise[4];

        pend_clr = xfer ? win_q : '0;
        if (!active) begin
            pend_clr[4:0] = '1;
        end
    end

    always_comb begin
        state_n = state;
        latch   = 1'b0;
        cand    = active ? pend : {pend[P_S], 5'b0};
        win_n   = top_bit(cand);
        op_n    = code_of(win_n);
        case (state)
            S_RUN: begin
                if (fail) begin
                    state_n = S_FAIL;
                end else if (|cand) begin
                    latch   = 1'b1;
                    state_n = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (op_ready) begin
                    state_n = S_RUN;
                end
            end
            S_FAIL: begin
                if (|cand) begin
                    latch   = 1'b1;
                    state_n = S_ISSUE;
                end
            end
            default: state_n = S_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!clrn) begin
            state <= S_RUN;
        end else begin
            state <= state_n;
        end
    end

    always_ff @(posedge clk) begin
        if (!clrn) begin
            key_q    <= '0;
            key_prev <= '0;
            level    <= '0;
            pend     <= '0;
            op_valid <= 1'b0;
            op_q     <= OP_NOP;
            win_q    <= '0;
        end else begin
            key_q    <= {key_space, key_up, key_down, key_right, key_left};
            key_prev <= key_q;
            level    <= score[6:3];
            // A re-set on the transfer edge survives the clear of the same bit.
            pend     <= (pend & ~pend_clr) | pend_set;
            if (latch) begin
                op_valid <= 1'b1;
                op_q     <= op_n;
                win_q    <= win_n;
            end else if (xfer) begin
                op_valid <= 1'b0;
                op_q     <= OP_NOP;
                win_q    <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < 3; i++) begin
            if (!clrn || !active || !key_q[i]) begin
                rep_cnt[i] <= '0;
            end else if ((i == 0 && rise_l) || (i == 1 && rise_r) || (i == 2 && rise[2])) begin
                rep_cnt[i] <= FIRST_C;
            end else if (rep_cnt[i] == CW'(1)) begin
                rep_cnt[i] <= RATE_C;
            end else if (rep_cnt[i] != '0) begin
                rep_cnt[i] <= rep_cnt[i] - CW'(1);
            end
        end
    end

    // The period is sampled only at wrap, so a level change applies to the next period.
    always_ff @(posedge clk) begin
        if (!clrn) begin
            grav_cnt <= '0;
            period_q <= BASE_C;
        end else if (!active) begin
            grav_cnt <= '0;
        end else if (grav_wrap) begin
            grav_cnt <= '0;
            period_q <= period_calc;
        end else if (xfer && win_q[P_D]) begin
            grav_cnt <= '0;
        end else begin
            grav_cnt <= grav_cnt + CW'(1);
        end
    end

endmodule
